prach_buffer_capture: RTL and testbench
=======================================

// Module: prach_buffer_capture
// PURPOSE
//   Per-channel (one CC x one antenna) PRACH sample capture buffer with two 1536-sample banks (ping-pong).
//   Writes decimated IQ samples of each PRACH occasion into a free bank, then raises done_req.
//   Serves the shared buffer readout through done_ack/rd_addr/rd_en/rd_data.
//   24 instances (3 CC x 8 ant) feed the readout arbiter, which ORs all rd_data, so an unselected instance drives zero.
// PARAMETERS
//   N_SAMPLES   1536  samples captured per occasion, and words read per readout
//   ADDR_W      11    width of the bank address and of rd_addr
//   RD_LATENCY  3     cycles from rd_addr/rd_en to rd_data (RAM read + pipeline); must be >= 2
//   CNT_W       16    width of ovf_cnt
// PORTS
//   clk       in   1       single clock
//   rst       in   1       asynchronous reset, active-high
//   din_dr    in   16      sample real part
//   din_di    in   16      sample imaginary part
//   din_dv    in   1       sample valid
//   sync_in   in   1       first sample of an occasion; only meaningful when din_dv=1
//   done_req  out  1       a full bank is waiting for readout
//   done_ack  in   1       readout grant; held high for the whole read of one bank
//   rd_addr   in   ADDR_W  read address, 0..N_SAMPLES-1
//   rd_en     in   1       read select; identical to done_ack at the readout side
//   rd_data   out  32      {di, dr}: [15:0]=dr, [31:16]=di; zero when not selected
//   ovf_pulse out  1       one-cycle pulse when an occasion is dropped
//   ovf_cnt   out  CNT_W   saturating count of dropped occasions
// BEHAVIOUR
//   Reset: async and active-high. Sets done_req=0, rd_data=0, ovf_pulse=0, ovf_cnt=0.
//     Both banks become FREE, wr_bank=0, rd_bank=0, writer goes to IDLE. RAM contents are not cleared.
//   Bank state per bank: FREE -> FULL (capture complete) -> READING (done_ack seen) -> FREE (done_ack falls).
//   Writer FSM IDLE/CAPTURE, wr_addr counter:
//     - IDLE with din_dv&sync_in and bank wr_bank FREE: write the sample at address 0, go to CAPTURE, wr_addr=1.
//     - IDLE with din_dv&sync_in and bank wr_bank not FREE: drop the occasion.
//       ovf_pulse=1 on the next cycle; ovf_cnt+1, saturating at all-ones. Stay IDLE.
//     - CAPTURE with din_dv: write at wr_addr, then wr_addr+1. Cycles without din_dv write nothing; the address holds.
//     - CAPTURE with din_dv&sync_in: restart in the same bank. Write at address 0, wr_addr=1. No overflow is counted.
//     - Write at address N_SAMPLES-1: the bank becomes FULL on the next cycle. wr_bank toggles; writer goes to IDLE.
//     - din_dv without sync_in while IDLE: the sample is ignored.
//   Handshake:
//     - done_req is registered: high in any cycle where bank rd_bank is FULL.
//     - First cycle done_ack=1: bank rd_bank becomes READING. done_req falls on the next cycle.
//       This must happen before the arbiter re-samples the request at the end of the read.
//     - done_ack 1->0: bank rd_bank becomes FREE and rd_bank toggles.
//       If the other bank is already FULL, done_req rises on the following cycle.
//     - Banks are read strictly in capture order.
//   Read datapath:
//     - While rd_en=1, RAM[rd_bank][rd_addr] appears on rd_data exactly RD_LATENCY cycles later.
//     - rd_en is pipelined alongside the read. rd_data=0 whenever the delayed rd_en is 0.
//     - rd_addr beyond N_SAMPLES-1 returns don't-care data but must not corrupt state.
//   Simultaneous events:
//     - Capture of bank X completes in the same cycle as release of bank Y: both take effect.
//     - A sync arriving in that same cycle sees the just-released bank as FREE only on the next cycle.
//       It is dropped if wr_bank is not FREE in the sync cycle.
//   Reset mid-readout or mid-capture: everything returns to the reset state immediately.
//     The in-flight occasion is lost and not counted.
// TESTING
//   T1 single occasion: sync + 1536 ramp samples (dr=n, di=~n) with din_dv=1.
//      -> done_req=1 one cycle after the last write.
//      ack held 1536 cycles, rd_addr 0..1535 -> rd_data={~n,n} at +3 cycles; 0 before and after.
//   T2 done_req drop: assert done_ack -> done_req=0 exactly one cycle later.
//      It stays 0 after ack falls when no second bank is full.
//   T3 ping-pong: occasions A and B back-to-back; ack delayed 2000 cycles.
//      -> A read first. done_req re-rises one cycle after ack falls; B data is read intact.
//   T4 overflow: three occasions, no ack -> third dropped.
//      ovf_pulse once, ovf_cnt=1, banks hold A and B unchanged.
//   T5 resync + gaps: din_dv 50% duty; second sync at sample 700.
//      -> bank holds only the new 1536 samples; ovf_cnt=0.
//   T6 async reset asserted mid-readout (rd_addr=800).
//      -> rd_data=0 and done_req=0 immediately. After release, a new occasion captures into bank 0.

Source files
------------

// File: rtl/prach_buffer_capture_if.sv
// Bus bundle for one PRACH capture channel: sample input, done handshake and shared readout.
interface prach_buffer_capture_if #(
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned CNT_W  = 16
);
    logic [15:0]       din_dr;
    logic [15:0]       din_di;
    logic              din_dv;
    logic              sync_in;
    logic              done_req;
    logic              done_ack;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_en;
    logic [31:0]       rd_data;
    logic              ovf_pulse;
    logic [CNT_W-1:0]  ovf_cnt;

    // Sample source and readout arbiter side
    modport master (
        output din_dr, din_di, din_dv, sync_in, done_ack, rd_addr, rd_en,
        input  done_req, rd_data, ovf_pulse, ovf_cnt
    );

    // Capture buffer side
    modport slave (
        input  din_dr, din_di, din_dv, sync_in, done_ack, rd_addr, rd_en,
        output done_req, rd_data, ovf_pulse, ovf_cnt
    );
endinterface

// File: rtl/prach_buffer_capture.sv
// Ping-pong PRACH sample capture buffer for one CC x antenna channel.
// Each occasion is written into a free bank; full banks are offered to the readout arbiter
// in capture order. rd_data is zero whenever this instance is not selected so that the
// arbiter can OR all instances together.
module prach_buffer_capture #(
    parameter int unsigned N_SAMPLES  = 1536,
    parameter int unsigned ADDR_W     = 11,
    parameter int unsigned RD_LATENCY = 3,
    parameter int unsigned CNT_W      = 16
) (
    input logic                   clk,
    input logic                   rst,
    prach_buffer_capture_if.slave bus
);

    // Writer states
    localparam logic [0:0] StIdle    = 1'b0;
    localparam logic [0:0] StCapture = 1'b1;

    // Per-bank states
    localparam logic [1:0] BankFree    = 2'd0;
    localparam logic [1:0] BankFull    = 2'd1;
    localparam logic [1:0] BankReading = 2'd2;

    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(N_SAMPLES - 1);

    // Writer state
    logic [0:0]        wr_state_q, wr_state_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic              wr_bank_q, wr_bank_d;

    // Bank bookkeeping and handshake
    logic [1:0][1:0]   bank_q, bank_d;
    logic              rd_bank_q, rd_bank_d;
    logic              done_req_q, done_req_d;

    // Overflow reporting
    logic              ovf_pulse_q, ovf_pulse_d;
    logic [CNT_W-1:0]  ovf_cnt_q, ovf_cnt_d;

    // Write port
    logic              wr_en;
    logic [ADDR_W-1:0] wr_ptr;
    logic              wr_done;
    logic [31:0]       wr_data;

    // Read datapath
    logic [ADDR_W-1:0] rd_idx;
    logic [31:0]       ram0_q, ram1_q;
    logic              rd_en_q;
    logic              rd_sel_q;
    logic [31:0]       dat_q [RD_LATENCY-1];

    // Sample storage; contents survive reset
    logic [31:0]       mem0 [N_SAMPLES];
    logic [31:0]       mem1 [N_SAMPLES];

    assign wr_data = {bus.din_di, bus.din_dr};

    // Writer FSM: start, restart, overflow detection and end-of-occasion
    always_comb begin
        wr_state_d  = wr_state_q;
        wr_addr_d   = wr_addr_q;
        wr_bank_d   = wr_bank_q;
        wr_en       = 1'b0;
        wr_ptr      = wr_addr_q;
        wr_done     = 1'b0;
        ovf_pulse_d = 1'b0;
        ovf_cnt_d   = ovf_cnt_q;

        case (wr_state_q)
            StIdle: begin
                if (bus.din_dv && bus.sync_in) begin
                    if (bank_q[wr_bank_q] == BankFree) begin
                        wr_en      = 1'b1;
                        wr_ptr     = '0;
                        wr_addr_d  = ADDR_W'(1);
                        wr_state_d = StCapture;
                    end else begin
                        // Target bank still owned by the reader: drop the whole occasion
                        ovf_pulse_d = 1'b1;
                        if (ovf_cnt_q != '1) begin
                            ovf_cnt_d = ovf_cnt_q + CNT_W'(1);
                        end
                    end
                end
            end
            StCapture: begin
                if (bus.din_dv) begin
                    wr_en     = 1'b1;
                    // A new sync restarts the occasion in the same bank
                    wr_ptr    = bus.sync_in ? '0 : wr_addr_q;
                    wr_addr_d = wr_ptr + ADDR_W'(1);
                end
            end
            default: begin
                wr_state_d = StIdle;
            end
        endcase

        if (wr_en && (wr_ptr == LastAddr)) begin
            wr_done    = 1'b1;
            wr_state_d = StIdle;
            wr_addr_d  = '0;
            wr_bank_d  = ~wr_bank_q;
        end
    end

    // Bank ownership and readout handshake
    always_comb begin
        bank_d    = bank_q;
        rd_bank_d = rd_bank_q;

        // The writer only ever completes a FREE bank, so this never collides with the reader
        if (wr_done) begin
            bank_d[wr_bank_q] = BankFull;
        end

        if ((bank_q[rd_bank_q] == BankFull) && bus.done_ack) begin
            bank_d[rd_bank_q] = BankReading;
        end else if ((bank_q[rd_bank_q] == BankReading) && !bus.done_ack) begin
            bank_d[rd_bank_q] = BankFree;
            rd_bank_d         = ~rd_bank_q;
        end

        // Registered request tracks the bank state it will see next cycle
        done_req_d = (bank_d[rd_bank_d] == BankFull);
    end

    // Control state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_state_q  <= StIdle;
            wr_addr_q   <= '0;
            wr_bank_q   <= 1'b0;
            bank_q      <= {BankFree, BankFree};
            rd_bank_q   <= 1'b0;
            done_req_q  <= 1'b0;
            ovf_pulse_q <= 1'b0;
            ovf_cnt_q   <= '0;
        end else begin
            wr_state_q  <= wr_state_d;
            wr_addr_q   <= wr_addr_d;
            wr_bank_q   <= wr_bank_d;
            bank_q      <= bank_d;
            rd_bank_q   <= rd_bank_d;
            done_req_q  <= done_req_d;
            ovf_pulse_q <= ovf_pulse_d;
            ovf_cnt_q   <= ovf_cnt_d;
        end
    end

    // Out-of-range read addresses are folded to 0 so they never index past the arrays
    assign rd_idx = (bus.rd_addr <= LastAddr) ? bus.rd_addr : '0;

    // Bank 0 RAM: write port plus registered read
    always_ff @(posedge clk) begin
        if (wr_en && !wr_bank_q) begin
            mem0[wr_ptr] <= wr_data;
        end
        ram0_q <= mem0[rd_idx];
    end

    // Bank 1 RAM: write port plus registered read
    always_ff @(posedge clk) begin
        if (wr_en && wr_bank_q) begin
            mem1[wr_ptr] <= wr_data;
        end
        ram1_q <= mem1[rd_idx];
    end

    // Read pipeline: select travels with the RAM read, then data is zero-gated and delayed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_en_q  <= 1'b0;
            rd_sel_q <= 1'b0;
            for (int i = 0; i < int'(RD_LATENCY) - 1; i++) begin
                dat_q[i] <= '0;
            end
        end else begin
            rd_en_q  <= bus.rd_en;
            rd_sel_q <= rd_bank_q;
            dat_q[0] <= rd_en_q ? (rd_sel_q ? ram1_q : ram0_q) : '0;
            for (int i = 1; i < int'(RD_LATENCY) - 1; i++) begin
                dat_q[i] <= dat_q[i-1];
            end
        end
    end

    assign bus.rd_data   = dat_q[RD_LATENCY-2];
    assign bus.done_req  = done_req_q;
    assign bus.ovf_pulse = ovf_pulse_q;
    assign bus.ovf_cnt   = ovf_cnt_q;

endmodule

// File: tb/tb_prach_buffer_capture.sv
// Scoreboard bench for prach_buffer_capture: stimulus pushes expected read words,
// a negedge monitor pops and compares whenever read data is due.
module tb_prach_buffer_capture;

    localparam int unsigned N      = 1536;
    localparam int unsigned ADDR_W = 11;
    localparam int unsigned CNT_W  = 16;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    prach_buffer_capture_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

    prach_buffer_capture #(
        .N_SAMPLES (N),
        .ADDR_W    (ADDR_W),
        .RD_LATENCY(3),
        .CNT_W     (CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    logic [31:0] exp_q [$];
    logic [2:0]  en_sh = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Sample n of occasion 'seed': dr = n + seed*4096, di = ~dr
    function automatic logic [31:0] pat(input int seed, input int n);
        logic [15:0] dr;
        dr = 16'(n + seed * 4096);
        return {~dr, dr};
    endfunction

    // Track when the bench expects read data, three edges after rd_en was sampled
    always @(posedge clk or posedge rst) begin
        if (rst) en_sh <= '0;
        else     en_sh <= {en_sh[1:0], bus.rd_en};
    end

    // Monitor: compare rd_data against the scoreboard, or against zero when unselected
    always @(negedge clk) begin
        if (!rst) begin
            if (en_sh[2]) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL rd_data_unexpected: got %h expected no data", bus.rd_data);
                end else begin
                    check("rd_data", bus.rd_data, exp_q.pop_front());
                end
            end else begin
                check("rd_data_idle", bus.rd_data, 32'h0);
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.din_dv = 1'b0; bus.sync_in = 1'b0;
        bus.done_ack = 1'b0; bus.rd_en = 1'b0; bus.rd_addr = '0;
        exp_q.delete();
        tick(); tick();
        rst = 1'b0;
        tick();
    endtask

    // Stream 'pre' junk samples (if any), then a full occasion 'seed'; sync on each start
    task automatic capture(input int seed, input int pre, input bit gaps, input bit drop);
        logic [31:0] w;
        for (int i = 0; i < pre + int'(N); i++) begin
            tick();
            if (i == 1) check("ovf_pulse", 32'(bus.ovf_pulse), 32'(drop));
            if (i == 2) check("ovf_pulse_clr", 32'(bus.ovf_pulse), 32'h0);
            w = (i < pre) ? pat(seed + 8, i) : pat(seed, i - pre);
            bus.din_dv  = 1'b1;
            bus.sync_in = (i == 0) || (i == pre);
            bus.din_dr  = w[15:0];
            bus.din_di  = w[31:16];
            if (gaps) begin
                tick();
                bus.din_dv  = 1'b0;
                bus.sync_in = 1'b0;
            end
        end
    endtask

    task automatic end_stream();
        tick();
        bus.din_dv  = 1'b0;
        bus.sync_in = 1'b0;
    endtask

    // Full readout of one bank with handshake timing checks
    task automatic readout(input int seed, input bit rerise);
        check("done_req_before_ack", 32'(bus.done_req), 32'h1);
        bus.done_ack = 1'b1;
        bus.rd_en    = 1'b1;
        bus.rd_addr  = '0;
        exp_q.push_back(pat(seed, 0));
        for (int a = 1; a < int'(N); a++) begin
            tick();
            if (a == 1) check("done_req_drop", 32'(bus.done_req), 32'h0);
            bus.rd_addr = ADDR_W'(a);
            exp_q.push_back(pat(seed, a));
        end
        tick();
        bus.done_ack = 1'b0;
        bus.rd_en    = 1'b0;
        bus.rd_addr  = '0;
        tick();
        check("done_req_after_release", 32'(bus.done_req), 32'(rerise));
        idle(4);
    endtask

    initial begin
        rst = 1'b1;
        bus.din_dr = '0; bus.din_di = '0; bus.din_dv = 1'b0; bus.sync_in = 1'b0;
        bus.done_ack = 1'b0; bus.rd_en = 1'b0; bus.rd_addr = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        tick();
        check("reset_done_req", 32'(bus.done_req), 32'h0);
        check("reset_ovf_pulse", 32'(bus.ovf_pulse), 32'h0);
        check("reset_ovf_cnt", 32'(bus.ovf_cnt), 32'h0);
        check("reset_rd_data", bus.rd_data, 32'h0);

        // T1/T2: single ramp occasion, request timing and full readout
        idle(2);
        capture(0, 0, 1'b0, 1'b0);
        check("t1_done_req_at_last_write", 32'(bus.done_req), 32'h0);
        end_stream();
        check("t1_done_req_after_last_write", 32'(bus.done_req), 32'h1);
        idle(3);
        readout(0, 1'b0);
        idle(3);
        check("t2_done_req_stays_low", 32'(bus.done_req), 32'h0);

        // T3: back-to-back occasions, delayed acknowledge, capture-order readout
        do_reset();
        capture(1, 0, 1'b0, 1'b0);
        capture(2, 0, 1'b0, 1'b0);
        end_stream();
        idle(2000);
        readout(1, 1'b1);
        readout(2, 1'b0);

        // T4: third occasion with both banks full is dropped
        do_reset();
        capture(3, 0, 1'b0, 1'b0);
        capture(4, 0, 1'b0, 1'b0);
        end_stream();
        idle(5);
        capture(5, 0, 1'b0, 1'b1);
        end_stream();
        check("t4_ovf_cnt", 32'(bus.ovf_cnt), 32'h1);
        readout(3, 1'b1);
        readout(4, 1'b0);
        check("t4_ovf_cnt_hold", 32'(bus.ovf_cnt), 32'h1);

        // T5: 50% duty input with a resync at sample 700
        do_reset();
        capture(6, 700, 1'b1, 1'b0);
        end_stream();
        idle(2);
        readout(6, 1'b0);
        check("t5_ovf_cnt", 32'(bus.ovf_cnt), 32'h0);

        // T6: asynchronous reset in the middle of a readout
        do_reset();
        capture(7, 0, 1'b0, 1'b0);
        end_stream();
        idle(2);
        check("t6_done_req", 32'(bus.done_req), 32'h1);
        bus.done_ack = 1'b1;
        bus.rd_en    = 1'b1;
        for (int a = 0; a <= 800; a++) begin
            if (a > 0) tick();
            bus.rd_addr = ADDR_W'(a);
            exp_q.push_back(pat(7, a));
        end
        @(posedge clk);
        #3;
        rst = 1'b1;
        bus.done_ack = 1'b0;
        bus.rd_en    = 1'b0;
        bus.rd_addr  = '0;
        exp_q.delete();
        #1;
        check("t6_rd_data_in_reset", bus.rd_data, 32'h0);
        check("t6_done_req_in_reset", 32'(bus.done_req), 32'h0);
        check("t6_ovf_cnt_in_reset", 32'(bus.ovf_cnt), 32'h0);
        idle(3);
        rst = 1'b0;
        tick();
        check("t6_done_req_after_reset", 32'(bus.done_req), 32'h0);
        capture(8, 0, 1'b0, 1'b0);
        end_stream();
        check("t6_done_req_new_capture", 32'(bus.done_req), 32'h1);
        readout(8, 1'b0);

        idle(5);
        check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
